// File: rtl/bit_pattern_tx.sv
// bit_pattern_tx: serial pattern source for the Moore "110" detector.
// Accepts {pattern, length, repeat} over a valid/ready handshake, shifts the
// pattern out MSB-first one bit per clock, and runs a golden copy of the
// detector so expect_z lines up cycle-for-cycle with the detector's Z.
module bit_pattern_tx #(
    parameter int unsigned PAT_W = 16,
    parameter int unsigned LEN_W = 5,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [PAT_W-1:0] load_pattern,
    input  logic [LEN_W-1:0] load_len,
    input  logic [CNT_W-1:0] load_repeat,
    input  logic             abort,
    output logic             X,
    output logic             bit_valid,
    output logic             done,
    output logic             expect_z
);

    // Transmitter states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Detector model states
    localparam logic [1:0] M_S0 = 2'd0;
    localparam logic [1:0] M_S1 = 2'd1;
    localparam logic [1:0] M_S2 = 2'd2;
    localparam logic [1:0] M_S3 = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [1:0]       model_q, model_d;
    logic             x_q, x_d;
    logic             bit_valid_q, bit_valid_d;
    logic             done_q, done_d;
    logic             load_ready_q, load_ready_d;
    logic             expect_z_q, expect_z_d;

    logic             load_fire;
    logic             load_empty;
    logic [LEN_W-1:0] load_top;
    logic             load_first_bit;
    logic             last_bit;
    logic [LEN_W-1:0] idx_nxt;
    logic             send_nxt_bit;
    logic [1:0]       model_step_q;

    // Select bit i of p; indices at or beyond PAT_W read as 0.
    function automatic logic pick_bit(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] i);
        logic b;
        b = 1'b0;
        for (int unsigned k = 0; k < PAT_W; k++) begin
            if (i == LEN_W'(k)) begin
                b = p[k];
            end
        end
        return b;
    endfunction

    // Moore "110" detector transition function.
    function automatic logic [1:0] det_next(input logic [1:0] s, input logic b);
        logic [1:0] n;
        n = M_S0;
        case (s)
            M_S0:    n = b ? M_S1 : M_S0;
            M_S1:    n = b ? M_S2 : M_S0;
            M_S2:    n = b ? M_S2 : M_S3;
            M_S3:    n = b ? M_S1 : M_S0;
            default: n = M_S0;
        endcase
        return n;
    endfunction

    // Handshake decode and bit-select datapath
    always_comb begin
        load_fire      = (state_q == ST_IDLE) && load_valid;
        load_empty     = (load_len == '0) || (load_repeat == '0);
        load_top       = load_empty ? '0 : (load_len - LEN_W'(1));
        load_first_bit = pick_bit(load_pattern, load_top);
        last_bit       = (idx_q == '0) && (rep_q == CNT_W'(1));
        // Wrap to the MSB of the pattern at the end of each repeat.
        idx_nxt        = (idx_q == '0) ? (len_q - LEN_W'(1)) : (idx_q - LEN_W'(1));
        send_nxt_bit   = pick_bit(pat_q, idx_nxt);
        // Model only advances on cycles that actually carry a bit.
        model_step_q   = bit_valid_q ? det_next(model_q, x_q) : model_q;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        len_d        = len_q;
        idx_d        = idx_q;
        rep_d        = rep_q;
        model_d      = model_q;
        x_d          = 1'b0;
        bit_valid_d  = 1'b0;
        done_d       = 1'b0;
        load_ready_d = 1'b0;
        expect_z_d   = expect_z_q;

        case (state_q)
            ST_IDLE: begin
                load_ready_d = 1'b1;
                if (load_fire) begin
                    pat_d        = load_pattern;
                    len_d        = load_len;
                    model_d      = M_S0;
                    expect_z_d   = 1'b0;
                    load_ready_d = 1'b0;
                    if (load_empty) begin
                        idx_d   = '0;
                        rep_d   = '0;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d       = load_top;
                        rep_d       = load_repeat;
                        state_d     = ST_SEND;
                        x_d         = load_first_bit;
                        bit_valid_d = 1'b1;
                    end
                end
            end

            ST_SEND: begin
                if (abort) begin
                    // The bit on the wire this cycle is still sent; the model
                    // is discarded so its update does not matter.
                    state_d      = ST_IDLE;
                    model_d      = M_S0;
                    expect_z_d   = 1'b0;
                    load_ready_d = 1'b1;
                    idx_d        = '0;
                    rep_d        = '0;
                end else begin
                    model_d    = model_step_q;
                    expect_z_d = (model_step_q == M_S3);
                    if (last_bit) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d       = idx_nxt;
                        x_d         = send_nxt_bit;
                        bit_valid_d = 1'b1;
                        if (idx_q == '0) begin
                            rep_d = rep_q - CNT_W'(1);
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d      = ST_IDLE;
                load_ready_d = 1'b1;
            end

            default: begin
                state_d      = ST_IDLE;
                model_d      = M_S0;
                expect_z_d   = 1'b0;
                load_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pat_q        <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            rep_q        <= '0;
            model_q      <= M_S0;
            x_q          <= 1'b0;
            bit_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
            expect_z_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            rep_q        <= rep_d;
            model_q      <= model_d;
            x_q          <= x_d;
            bit_valid_q  <= bit_valid_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
            expect_z_q   <= expect_z_d;
        end
    end

    assign X          = x_q;
    assign bit_valid  = bit_valid_q;
    assign done       = done_q;
    assign load_ready = load_ready_q;
    assign expect_z   = expect_z_q;

endmodule

// File: tb/tb_bit_pattern_tx.sv
// Bench for bit_pattern_tx: directed and random loads checked cycle by cycle
// against a stream-level model (expected bit list plus "last three bits were
// 110" rule for expect_z).
module tb_bit_pattern_tx;

    localparam int PAT_W = 16;
    localparam int LEN_W = 5;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [PAT_W-1:0] load_pattern = '0;
    logic [LEN_W-1:0] load_len = '0;
    logic [CNT_W-1:0] load_repeat = '0;
    logic             abort = 1'b0;
    logic             X;
    logic             bit_valid;
    logic             done;
    logic             expect_z;

    int n_total = 0;
    int n_pass  = 0;

    logic exp_bits[$];
    logic obs_x[$];
    logic obs_z[$];

    always #5 clk = ~clk;

    bit_pattern_tx #(
        .PAT_W(PAT_W),
        .LEN_W(LEN_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_pattern(load_pattern),
        .load_len    (load_len),
        .load_repeat (load_repeat),
        .abort       (abort),
        .X           (X),
        .bit_valid   (bit_valid),
        .done        (done),
        .expect_z    (expect_z)
    );

    // expect_z in cycle t: the three bits sent in cycles t-3..t-1 were 1,1,0.
    function automatic logic model_z(input int t, input int n);
        int tt;
        tt = (t > n + 1) ? n + 1 : t;
        if (tt < 4) return 1'b0;
        return exp_bits[tt-4] == 1'b1 && exp_bits[tt-3] == 1'b1 && exp_bits[tt-2] == 1'b0;
    endfunction

    // Entered at a negedge with the DUT idle; returns at the negedge of the
    // last checked cycle. With hold_next, load_valid stays high carrying the
    // next request so it is taken in the first cycle load_ready returns.
    task automatic run_load(input logic [PAT_W-1:0] p, input int len, input int rep,
                            input int abort_at, input logic hold_next,
                            input logic [PAT_W-1:0] np, input int nlen, input int nrep,
                            input string tag);
        int n;
        int last;
        logic [4:0] exp_v;
        logic [4:0] got_v;
        exp_bits.delete();
        for (int i = 0; i < len * rep; i++) begin
            exp_bits.push_back(p[len - 1 - (i % len)]);
        end
        n    = len * rep;
        last = (abort_at > 0) ? abort_at + 2 : n + 2;
        load_valid   = 1'b1;
        load_pattern = p;
        load_len     = LEN_W'(len);
        load_repeat  = CNT_W'(rep);
        @(posedge clk);
        #1;
        if (hold_next) begin
            load_pattern = np;
            load_len     = LEN_W'(nlen);
            load_repeat  = CNT_W'(nrep);
        end else begin
            load_valid = 1'b0;
        end
        obs_x.delete();
        obs_z.delete();
        for (int t = 1; t <= last; t++) begin
            abort = (t == abort_at);
            @(negedge clk);
            // {load_ready, bit_valid, X, done, expect_z}
            if (abort_at > 0 && t > abort_at) exp_v = 5'b10000;
            else if (t <= n) exp_v = {1'b0, 1'b1, exp_bits[t-1], 1'b0, model_z(t, n)};
            else if (t == n + 1) exp_v = {1'b0, 1'b0, 1'b0, 1'b1, model_z(t, n)};
            else exp_v = {1'b1, 1'b0, 1'b0, 1'b0, model_z(t, n)};
            got_v = {load_ready, bit_valid, X, done, expect_z};
            obs_x.push_back(X);
            obs_z.push_back(expect_z);
            n_total++;
            if (got_v !== exp_v) begin
                $display("FAIL %s cycle %0d: {ready,valid,X,done,z} got %b expected %b",
                         tag, t, got_v, exp_v);
            end else begin
                n_pass++;
            end
            if (t < last) begin
                @(posedge clk);
                #1;
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] got_v;
        #1 reset = 1'b1;
        #2;
        got_v = {load_ready, bit_valid, X, done, expect_z};
        n_total++;
        if (got_v !== 5'b10000) $display("FAIL reset_value: got %b expected 10000", got_v);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got_v = {load_ready, bit_valid, X, done, expect_z};
            n_total++;
            if (got_v !== 5'b10000) $display("FAIL idle_after_reset %0d: got %b expected 10000", i, got_v);
            else n_pass++;
        end
    endtask

    task automatic test_110();
        logic [5:0] xv;
        logic [6:0] zv;
        run_load(16'b110, 3, 2, 0, 1'b0, '0, 0, 0, "p110");
        xv = '0;
        zv = '0;
        for (int i = 0; i < 6; i++) xv = {xv[4:0], obs_x[i]};
        for (int i = 0; i < 7; i++) zv = {zv[5:0], obs_z[i]};
        n_total++;
        if (xv !== 6'b110110) $display("FAIL p110_x_stream: got %b expected 110110", xv);
        else n_pass++;
        n_total++;
        if (zv !== 7'b0001001) $display("FAIL p110_z_stream: got %b expected 0001001", zv);
        else n_pass++;
    endtask

    task automatic test_11010();
        logic [4:0] xv;
        logic [5:0] zv;
        run_load(16'b11010, 5, 1, 0, 1'b0, '0, 0, 0, "p11010");
        xv = '0;
        zv = '0;
        for (int i = 0; i < 5; i++) xv = {xv[3:0], obs_x[i]};
        for (int i = 0; i < 6; i++) zv = {zv[4:0], obs_z[i]};
        n_total++;
        if (xv !== 5'b11010) $display("FAIL p11010_x_stream: got %b expected 11010", xv);
        else n_pass++;
        n_total++;
        if (zv !== 6'b000100) $display("FAIL p11010_z_stream: got %b expected 000100", zv);
        else n_pass++;
    endtask

    task automatic test_len0();
        run_load(16'hBEEF, 0, 5, 0, 1'b0, '0, 0, 0, "len0");
        run_load(16'h00F3, 8, 0, 0, 1'b0, '0, 0, 0, "rep0");
    endtask

    task automatic test_abort();
        run_load(16'h00A7, 8, 1, 2, 1'b0, '0, 0, 0, "abort_c2");
        // Abort on the final bit still suppresses done.
        run_load(16'h0006, 3, 1, 3, 1'b0, '0, 0, 0, "abort_last");
    endtask

    task automatic test_back_to_back();
        run_load(16'h000B, 4, 2, 0, 1'b1, 16'h0006, 3, 3, "b2b_first");
        run_load(16'h0006, 3, 3, 0, 1'b0, '0, 0, 0, "b2b_second");
    endtask

    task automatic test_random();
        int len;
        int rep;
        int ab;
        logic [PAT_W-1:0] p;
        for (int it = 0; it < 25; it++) begin
            len = $urandom_range(0, PAT_W);
            rep = $urandom_range(0, 5);
            p   = PAT_W'($urandom);
            ab  = 0;
            if (len * rep > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, len * rep);
            run_load(p, len, rep, ab, 1'b0, '0, 0, 0, $sformatf("rand%0d", it));
        end
    endtask

    task automatic test_reset_mid_send();
        logic [4:0] got_v;
        load_valid   = 1'b1;
        load_pattern = 16'h00D6;
        load_len     = LEN_W'(8);
        load_repeat  = CNT_W'(3);
        @(posedge clk);
        #1 load_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        got_v = {load_ready, bit_valid, X, done, expect_z};
        n_total++;
        if (got_v !== 5'b10000) $display("FAIL mid_send_reset_async: got %b expected 10000", got_v);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            got_v = {load_ready, bit_valid, X, done, expect_z};
            n_total++;
            if (got_v !== 5'b10000) $display("FAIL after_mid_reset %0d: got %b expected 10000", i, got_v);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_110();
        test_11010();
        test_len0();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
